// File: rtl/mult_pkg.sv
// Shared types and widths for the dot-product sequencer and its multiplier.
package mult_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned PRODUCT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } dp_state_t;

    typedef struct packed {
        logic                 last;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mult_dot_product_if.sv
// Operand stream in, multiplier handshake, and dot-product result out.
interface mult_dot_product_if #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned CNT_W = 16
) ();
    import mult_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_a;
    logic [OPERAND_W-1:0] in_b;
    logic                 in_last;

    logic                 mult_start;
    logic [OPERAND_W-1:0] mult_a;
    logic [OPERAND_W-1:0] mult_b;
    logic                 mult_busy;
    logic [PRODUCT_W-1:0] mult_product;

    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic [CNT_W-1:0]     out_count;

    // Sequencer view.
    modport slave (
        input  in_valid, in_a, in_b, in_last,
        input  mult_busy, mult_product,
        input  out_ready,
        output in_ready,
        output mult_start, mult_a, mult_b,
        output out_valid, out_sum, out_count
    );

    // Environment view: operand producer, multiplier and result consumer.
    modport master (
        output in_valid, in_a, in_b, in_last,
        output mult_busy, mult_product,
        output out_ready,
        input  in_ready,
        input  mult_start, mult_a, mult_b,
        input  out_valid, out_sum, out_count
    );

endinterface

// File: rtl/mult32x32.sv
// Iterative shift-add 32x32 unsigned multiplier, one multiplier bit per cycle.
module mult32x32
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    output logic                 busy_o,
    output logic [PRODUCT_W-1:0] product_o
);

    logic                 busy_q, busy_d;
    logic [PRODUCT_W-1:0] acc_q, acc_d;
    logic [PRODUCT_W-1:0] mcand_q, mcand_d;
    logic [OPERAND_W-1:0] mplier_q, mplier_d;
    logic [4:0]           bit_q, bit_d;

    assign busy_o    = busy_q;
    assign product_o = acc_q;

    // Load on start, otherwise consume one multiplier bit per busy cycle.
    always_comb begin
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        bit_d    = bit_q;
        if (start_i) begin
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = PRODUCT_W'(a_i);
            mplier_d = b_i;
            bit_d    = '0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bit_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered full flag, no fall-through.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             do_push_c, do_pop_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = full_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_c = push_i && !full_q;
    assign do_pop_c  = pop_i && !empty_o;

    // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // Control state; full is held during reset so nothing is accepted until the first clean cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mult_dot_product.sv
// Feeds buffered operand pairs to mult32x32 and accumulates products into dot-product sums.
module mult_dot_product
    import mult_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACC_W      = 72,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    mult_dot_product_if.slave bus
);

    localparam int unsigned PAIR_W = $bits(operand_pair_t);

    dp_state_t            state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OPERAND_W-1:0] mult_a_q, mult_a_d;
    logic [OPERAND_W-1:0] mult_b_q, mult_b_d;
    logic                 cur_last_q, cur_last_d;
    logic                 mult_start_q, mult_start_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_sum_q, out_sum_d;
    logic [CNT_W-1:0]     out_count_q, out_count_d;

    logic [ACC_W-1:0]     acc_sum_c;
    logic [CNT_W-1:0]     cnt_inc_c;
    operand_pair_t        in_pair_c;
    operand_pair_t        head_c;
    logic                 fifo_push_c;
    logic                 fifo_pop_c;
    logic                 fifo_full;
    logic                 fifo_empty_c;

    assign in_pair_c   = {bus.in_last, bus.in_a, bus.in_b};
    assign fifo_push_c = bus.in_valid && !fifo_full;
    assign acc_sum_c   = acc_q + ACC_W'(bus.mult_product);
    assign cnt_inc_c   = cnt_q + CNT_W'(1);

    assign bus.in_ready   = !fifo_full;
    assign bus.mult_start = mult_start_q;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_count  = out_count_q;

    // Operand-pair buffer between the input stream and the multiplier.
    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push_c),
        .wdata_i (in_pair_c),
        .pop_i   (fifo_pop_c),
        .rdata_o (head_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty_c)
    );

    // Sequencer: pop, pulse start, wait out the multiplier, accumulate, present on last.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        cur_last_d   = cur_last_q;
        mult_start_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_count_d  = out_count_q;
        fifo_pop_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_c) begin
                    fifo_pop_c   = 1'b1;
                    mult_a_d     = head_c.a;
                    mult_b_d     = head_c.b;
                    cur_last_d   = head_c.last;
                    mult_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Multiplier only raises busy after sampling start, so busy is not examined here.
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.mult_busy) begin
                    if (cur_last_q) begin
                        out_sum_d   = acc_sum_c;
                        out_count_d = cnt_inc_c;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = OUT;
                    end else begin
                        acc_d   = acc_sum_c;
                        cnt_d   = cnt_inc_c;
                        state_d = IDLE;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            cur_last_q   <= 1'b0;
            mult_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            cur_last_q   <= cur_last_d;
            mult_start_q <= mult_start_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_count_q  <= out_count_d;
        end
    end

endmodule

// File: tb/tb_mult_dot_product.sv
// Bench for mult_dot_product driving a real mult32x32, checked against a sum-of-products model.
module tb_mult_dot_product;
    import mult_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ACC_W      = 72;
    localparam int unsigned CNT_W      = 16;
    localparam int          WAIT_LIMIT = 400;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mult_dot_product_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mult_dot_product #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ACC_W      (ACC_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mult32x32 u_mult (
        .clk       (clk),
        .reset     (reset),
        .start_i   (bus.mult_start),
        .a_i       (bus.mult_a),
        .b_i       (bus.mult_b),
        .busy_o    (bus.mult_busy),
        .product_o (bus.mult_product)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the monitor.
    int               start_count  = 0;
    int               start_double = 0;
    logic             prev_start   = 1'b0;
    logic [ACC_W-1:0] obs_sum_q [$];
    logic [CNT_W-1:0] obs_cnt_q [$];

    // Written only by the main sequence.
    int               obs_rd = 0;
    int               exp_rd = 0;
    logic [ACC_W-1:0] exp_sum_q [$];
    logic [CNT_W-1:0] exp_cnt_q [$];
    logic [ACC_W-1:0] model_acc   = '0;
    int               model_terms = 0;
    logic [31:0]      bp_a [6];
    logic [31:0]      bp_b [6];
    logic             bp_l [6];
    int               idx;
    int               accepted;
    int               s0;
    int               n_obs;
    int               waited;
    logic             hs;
    logic             prev_ready;
    logic             seen_pop;

    // Record completed result handshakes and start pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                obs_sum_q.push_back(bus.out_sum);
                obs_cnt_q.push_back(bus.out_count);
            end
            if (bus.mult_start) begin
                start_count++;
                if (prev_start) start_double++;
            end
        end
        prev_start = bus.mult_start;
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Dot product as plain arithmetic: running sum of a*b, closed by a last-tagged pair.
    function automatic void model_add(input logic [31:0] a, input logic [31:0] b, input logic last);
        model_acc = model_acc + ACC_W'(64'(a) * 64'(b));
        model_terms++;
        if (last) begin
            exp_sum_q.push_back(model_acc);
            exp_cnt_q.push_back(CNT_W'(model_terms));
            model_acc   = '0;
            model_terms = 0;
        end
    endfunction

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic last, input bit track);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < WAIT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        check("push_accept", 128'(w < WAIT_LIMIT), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (track) model_add(a, b, last);
    endtask

    task automatic offer(input int i);
        bus.in_valid = 1'b1;
        bus.in_a     = bp_a[i];
        bus.in_b     = bp_b[i];
        bus.in_last  = bp_l[i];
    endtask

    task automatic wait_results(input int n);
        int w;
        w = 0;
        while (obs_sum_q.size() < n && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("result_arrival", 128'(obs_sum_q.size() >= n), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string tag, input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c);
        check({tag, "_present"}, 128'(obs_sum_q.size() > obs_rd), 128'(1));
        if (obs_sum_q.size() > obs_rd) begin
            check({tag, "_sum"}, 128'(obs_sum_q[obs_rd]), 128'(s));
            check({tag, "_count"}, 128'(obs_cnt_q[obs_rd]), 128'(c));
            obs_rd++;
        end
    endtask

    task automatic expect_model(input string tag);
        expect_result(tag, exp_sum_q[exp_rd], exp_cnt_q[exp_rd]);
        exp_rd++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_mult_start", 128'(bus.mult_start), 128'(0));
        check("rst_mult_a", 128'(bus.mult_a), 128'(0));
        check("rst_mult_b", 128'(bus.mult_b), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_sum", 128'(bus.out_sum), 128'(0));
        check("rst_out_count", 128'(bus.out_count), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready_lo", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        check("rel_in_ready_hi", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Single term.
        bus.out_ready = 1'b1;
        s0 = start_count;
        push_pair(32'h17, 32'h2D, 1'b1, 1'b0);
        wait_results(obs_rd + 1);
        expect_result("single", 72'h40B, 16'd1);
        check("single_starts", 128'(start_count - s0), 128'(1));

        // Three terms back-to-back.
        s0 = start_count;
        push_pair(32'd2, 32'd3, 1'b0, 1'b0);
        push_pair(32'd4, 32'd5, 1'b0, 1'b0);
        push_pair(32'd6, 32'd7, 1'b1, 1'b0);
        wait_results(obs_rd + 1);
        expect_result("three", 72'h44, 16'd3);
        check("three_starts", 128'(start_count - s0), 128'(3));

        // Maximum operands.
        push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_results(obs_rd + 1);
        expect_result("max", 72'h2_FFFF_FFFA_0000_0003, 16'd3);

        // Split sums; the second also shows the accumulator was cleared.
        push_pair(32'd1, 32'd1, 1'b1, 1'b0);
        push_pair(32'd3, 32'd3, 1'b1, 1'b0);
        wait_results(obs_rd + 2);
        expect_result("split0", 72'h1, 16'd1);
        expect_result("split1", 72'h9, 16'd1);

        // Backpressure: stall the consumer with in_valid held high.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = $urandom();
            bp_b[i] = $urandom();
        end
        bp_l[0] = 1'b1; bp_l[1] = 1'b0; bp_l[2] = 1'b1;
        bp_l[3] = 1'b0; bp_l[4] = 1'b1; bp_l[5] = 1'b1;
        bus.out_ready = 1'b0;
        push_pair(bp_a[0], bp_b[0], bp_l[0], 1'b1);
        idx      = 1;
        accepted = 0;
        offer(idx);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            if (c == 50 || c == 75) begin
                check("bp_hold_valid", 128'(bus.out_valid), 128'(1));
                check("bp_hold_sum", 128'(bus.out_sum), 128'(exp_sum_q[exp_rd]));
                check("bp_hold_count", 128'(bus.out_count), 128'(1));
            end
            @(posedge clk);
            #1;
            if (hs) begin
                model_add(bp_a[idx], bp_b[idx], bp_l[idx]);
                accepted++;
                idx++;
                offer(idx);
            end
        end
        @(negedge clk);
        check("bp_accepted", 128'(accepted), 128'(FIFO_DEPTH));
        check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        prev_ready = 1'b1;
        seen_pop   = 1'b0;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            if (c == 1) check("bp_valid_drop", 128'(bus.out_valid), 128'(0));
            if (!seen_pop && bus.mult_start) begin
                seen_pop = 1'b1;
                check("bp_ready_before_pop", 128'(prev_ready), 128'(0));
                check("bp_ready_after_pop", 128'(bus.in_ready), 128'(1));
            end
            prev_ready = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                model_add(bp_a[idx], bp_b[idx], bp_l[idx]);
                idx++;
                if (idx < 6) offer(idx);
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_all_pushed", 128'(idx), 128'(6));
        wait_results(obs_rd + 4);
        for (int r = 0; r < 4; r++) expect_model("bp_result");

        // Random groups of 1..4 terms, occasionally with all-ones operands.
        for (int g = 0; g < 5; g++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int t = 0; t < len; t++) begin
                logic [31:0] ra, rb;
                ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
                rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
                push_pair(ra, rb, (t == len - 1), 1'b1);
            end
        end
        wait_results(obs_rd + 5);
        for (int r = 0; r < 5; r++) expect_model("rand_result");

        // Reset while the multiplier is busy.
        push_pair(32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        waited = 0;
        @(negedge clk);
        while (bus.mult_busy !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_busy_seen", 128'(bus.mult_busy), 128'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_mid_mult_a", 128'(bus.mult_a), 128'(0));
        check("rst_mid_in_ready_lo", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        check("rst_mid_in_ready_hi", 128'(bus.in_ready), 128'(1));
        n_obs = obs_sum_q.size();
        repeat (60) @(negedge clk);
        check("rst_no_stale", 128'(obs_sum_q.size()), 128'(n_obs));
        @(posedge clk);
        #1;
        push_pair(32'd5, 32'd7, 1'b1, 1'b0);
        wait_results(obs_rd + 1);
        expect_result("rst_after", 72'h23, 16'd1);

        check("start_single_cycle", 128'(start_double), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
